// File: rtl/iomem_latency_bridge.sv
// iomem bridge to a fixed-latency RAM port plus a 64-bit timer/compare block; unmapped accesses get err.
// Ready after RD/WR_LATENCY cycles for RAM, 1 cycle otherwise; requester holds valid until the ready pulse.
module iomem_latency_bridge #(
  parameter logic [31:0] RAM_BASE_ADDR   = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK_ADDR   = 32'h000f_ffff,
  parameter logic [31:0] TIMER_BASE_ADDR = 32'h3000_0000,
  parameter int          RD_LATENCY      = 16,
  parameter int          WR_LATENCY      = 16,
  parameter int          RAM_ADDR_W      = 17
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iomem_valid_i,
  output logic                  iomem_ready_o,
  input  logic [3:0]            iomem_wstrb_i,
  input  logic [31:0]           iomem_addr_i,
  input  logic [31:0]           iomem_wdata_i,
  output logic [31:0]           iomem_rdata_o,
  output logic                  iomem_err_o,
  output logic [RAM_ADDR_W-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  output logic                  mem_rd_en_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  timer_irq_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RAM_WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_ram_rd;
  logic [31:0]           r_rdata;
  logic [RAM_ADDR_W-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_wstrb;
  logic                  r_mem_rd_en;
  logic [63:0]           r_timer;
  logic [63:0]           r_cmp;
  logic                  r_irq;

  logic                  w_accept;
  logic                  w_is_ram;
  logic                  w_is_timer;
  logic                  w_is_write;
  logic                  w_timer_wr;
  logic [1:0]            w_reg_sel;
  logic [31:0]           w_timer_rdata;

  assign w_accept   = (r_state == IDLE) && iomem_valid_i;
  assign w_is_ram   = (iomem_addr_i & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
  assign w_is_timer = (iomem_addr_i & ~32'h0000_000f) == TIMER_BASE_ADDR;
  assign w_is_write = iomem_wstrb_i != 4'd0;
  assign w_timer_wr = w_accept && w_is_timer && w_is_write;
  assign w_reg_sel  = iomem_addr_i[3:2];

  function automatic logic [31:0] f_merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    w_timer_rdata = r_timer[31:0];
    case (w_reg_sel)
      2'd1:    w_timer_rdata = r_timer[63:32];
      2'd2:    w_timer_rdata = r_cmp[31:0];
      2'd3:    w_timer_rdata = r_cmp[63:32];
      default: w_timer_rdata = r_timer[31:0];
    endcase
  end

  // A write to a timer half replaces this cycle's increment; the other half is left alone (no carry).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timer <= 64'd0;
      r_cmp   <= '1;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= r_timer >= r_cmp;
      if (w_timer_wr && !w_reg_sel[1]) begin
        if (w_reg_sel[0]) r_timer[63:32] <= f_merge(r_timer[63:32], iomem_wdata_i, iomem_wstrb_i);
        else              r_timer[31:0]  <= f_merge(r_timer[31:0], iomem_wdata_i, iomem_wstrb_i);
      end else begin
        r_timer <= r_timer + 64'd1;
      end
      if (w_timer_wr && w_reg_sel[1]) begin
        if (w_reg_sel[0]) r_cmp[63:32] <= f_merge(r_cmp[63:32], iomem_wdata_i, iomem_wstrb_i);
        else              r_cmp[31:0]  <= f_merge(r_cmp[31:0], iomem_wdata_i, iomem_wstrb_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_mem_rd_en <= 1'b0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_mem_wstrb <= 4'd0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_ram) begin
            r_mem_addr  <= iomem_addr_i[RAM_ADDR_W+1:2];
            r_mem_wdata <= iomem_wdata_i;
            r_ram_rd    <= !w_is_write;
            r_state     <= RAM_WAIT;
            if (w_is_write) begin
              r_mem_wstrb <= iomem_wstrb_i;
              r_cnt       <= 8'(WR_LATENCY - 1);
            end else begin
              r_mem_rd_en <= 1'b1;
              r_cnt       <= 8'(RD_LATENCY - 1);
            end
          end else if (w_accept) begin
            r_state  <= RESP;
            r_ready  <= 1'b1;
            r_err    <= !w_is_timer;
            r_ram_rd <= 1'b0;
            r_rdata  <= (w_is_timer && !w_is_write) ? w_timer_rdata : 32'd0;
          end
        end
        RAM_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_ready <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          // Ready lasts one cycle; IDLE next so a held valid cannot re-accept during ready.
          r_ready  <= 1'b0;
          r_err    <= 1'b0;
          r_ram_rd <= 1'b0;
          r_rdata  <= 32'd0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign iomem_ready_o = r_ready;
  assign iomem_err_o   = r_err;
  assign iomem_rdata_o = (r_ready && r_ram_rd) ? mem_rdata_i : r_rdata;
  assign mem_addr_o    = r_mem_addr;
  assign mem_wdata_o   = r_mem_wdata;
  assign mem_wstrb_o   = r_mem_wstrb;
  assign mem_rd_en_o   = r_mem_rd_en;
  assign timer_irq_o   = r_irq;

endmodule

// File: tb/tb_iomem_latency_bridge.sv
// Randomized bench for iomem_latency_bridge: transaction-level model checked every cycle, plus directed scenarios.
module tb_iomem_latency_bridge;
  localparam int AW  = 17;
  localparam int RDL = 16;
  localparam int WRL = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          iomem_valid_i = 1'b0;
  logic          iomem_ready_o;
  logic [3:0]    iomem_wstrb_i = 4'd0;
  logic [31:0]   iomem_addr_i = 32'd0;
  logic [31:0]   iomem_wdata_i = 32'd0;
  logic [31:0]   iomem_rdata_o;
  logic          iomem_err_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_wstrb_o;
  logic          mem_rd_en_o;
  logic [31:0]   mem_rdata_i = 32'd0;
  logic          timer_irq_o;

  iomem_latency_bridge #(.RD_LATENCY(RDL), .WR_LATENCY(WRL), .RAM_ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .iomem_valid_i(iomem_valid_i), .iomem_ready_o(iomem_ready_o),
    .iomem_wstrb_i(iomem_wstrb_i), .iomem_addr_i(iomem_addr_i), .iomem_wdata_i(iomem_wdata_i),
    .iomem_rdata_o(iomem_rdata_o), .iomem_err_o(iomem_err_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_rdata_i(mem_rdata_i), .timer_irq_o(timer_irq_o));

  always #5 clk_i = ~clk_i;

  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  always @(posedge clk_i) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_i;
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  localparam int K_RAM = 0, K_TMR = 1, K_UNM = 2;
  bit          m_active;
  int          m_kind, m_c0, m_rdy_cyc;
  bit          m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic [AW-1:0] ma_old, ma_new;
  logic [31:0] mw_old, mw_new;
  int          ma_cyc;
  // timer(k) = base + (k - base_cyc) on the current segment, previous segment before it
  logic [63:0] t_base, t_prev;
  int          t_base_cyc, t_prev_cyc;
  logic [63:0] c_val, c_prev;
  int          c_cyc;

  function automatic logic [63:0] m_timer(input int k);
    if (k >= t_base_cyc) return t_base + 64'(k - t_base_cyc);
    return t_prev + 64'(k - t_prev_cyc);
  endfunction

  function automatic logic [63:0] m_cmp(input int k);
    return (k >= c_cyc) ? c_val : c_prev;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset(input int k);
    m_active = 0;
    ma_old = '0; ma_new = '0; mw_old = '0; mw_new = '0; ma_cyc = k;
    t_base = 64'd0; t_prev = 64'd0; t_base_cyc = k; t_prev_cyc = k;
    c_val = '1; c_prev = '1; c_cyc = k;
  endtask

  task automatic model_issue(input int c0, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [63:0] tv, cv, nv;
    m_active = 1; m_c0 = c0; m_wr = (s != 4'd0); m_wstrb = s; m_rdata = 32'd0;
    if ((a & 32'hFFF0_0000) == 32'h4000_0000) begin
      m_kind    = K_RAM;
      m_rdy_cyc = c0 + (m_wr ? WRL : RDL);
      ma_old = (c0 >= ma_cyc) ? ma_new : ma_old;
      mw_old = (c0 >= ma_cyc) ? mw_new : mw_old;
      ma_new = a[AW+1:2]; mw_new = d; ma_cyc = c0 + 1;
    end else if ((a & 32'hFFFF_FFF0) == 32'h3000_0000) begin
      m_kind = K_TMR; m_rdy_cyc = c0 + 1;
      tv = m_timer(c0); cv = m_cmp(c0);
      if (!m_wr) begin
        case (a[3:2])
          2'd0: m_rdata = tv[31:0];
          2'd1: m_rdata = tv[63:32];
          2'd2: m_rdata = cv[31:0];
          default: m_rdata = cv[63:32];
        endcase
      end else if (a[3] == 1'b0) begin
        nv = a[2] ? {bmerge(tv[63:32], d, s), tv[31:0]} : {tv[63:32], bmerge(tv[31:0], d, s)};
        t_prev = t_base; t_prev_cyc = t_base_cyc; t_base = nv; t_base_cyc = c0 + 1;
      end else begin
        nv = a[2] ? {bmerge(cv[63:32], d, s), cv[31:0]} : {cv[63:32], bmerge(cv[31:0], d, s)};
        c_prev = c_val; c_val = nv; c_cyc = c0 + 1;
      end
    end else begin
      m_kind = K_UNM; m_rdy_cyc = c0 + 1;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      logic [72+AW-1:0] act, exp;
      logic e_rdy, e_err, e_rden, e_irq;
      logic [31:0] e_rdata, e_wd;
      logic [3:0] e_ws;
      logic [AW-1:0] e_ma;
      int k;
      k = cyc;
      if (rst_at_edge) begin
        exp = '0;
      end else begin
        e_rdy   = m_active && (k == m_rdy_cyc);
        e_err   = e_rdy && (m_kind == K_UNM);
        e_rdata = !e_rdy ? 32'd0 : ((m_kind == K_RAM && !m_wr) ? mem_rdata_i : m_rdata);
        e_rden  = m_active && m_kind == K_RAM && !m_wr && k == m_c0 + 1;
        e_ws    = (m_active && m_kind == K_RAM && m_wr && k == m_c0 + 1) ? m_wstrb : 4'd0;
        e_ma    = (k >= ma_cyc) ? ma_new : ma_old;
        e_wd    = (k >= ma_cyc) ? mw_new : mw_old;
        e_irq   = m_timer(k - 1) >= m_cmp(k - 1);
        exp = {e_rdy, e_err, e_rdata, e_rden, e_ws, e_ma, e_wd, e_irq};
      end
      act = {iomem_ready_o, iomem_err_o, iomem_rdata_o, mem_rd_en_o, mem_wstrb_o, mem_addr_o,
             mem_wdata_o, timer_irq_o};
      check("cycle_outputs{rdy,err,rdata,rden,wstrb,maddr,mwdata,irq}", act, exp);
    end
  end

  initial begin
    forever begin
      @(posedge clk_i); #1;
      mem_rdata_i = $urandom;
    end
  end

  // ---------------- driver ----------------
  int          res_lat, res_rden_off, res_wstrb_off, res_wstrb_cnt;
  logic        res_err;
  logic [31:0] res_rdata, res_rdata_in;
  logic [3:0]  res_wstrb_seen;
  logic [AW-1:0] res_addr_seen;

  task automatic apply_reset();
    rst_i = 1'b1;
    iomem_valid_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    rst_i = 1'b0;
    model_reset(cyc);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after ready.
  task automatic do_txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input int drop_at, input int rst_at);
    bit done, aborted;
    done = 0; aborted = 0;
    res_lat = -1; res_rden_off = -1; res_wstrb_off = -1; res_wstrb_cnt = 0;
    res_err = 0; res_rdata = 0; res_rdata_in = 0; res_wstrb_seen = 0; res_addr_seen = 0;
    model_issue(cyc, a, s, d);
    iomem_valid_i = 1'b1; iomem_addr_i = a; iomem_wstrb_i = s; iomem_wdata_i = d;
    for (int off = 0; off < 300; off++) begin
      @(negedge clk_i);
      if (off > 0 && off == drop_at) iomem_valid_i = 1'b0;
      if (mem_rd_en_o) begin res_rden_off = off; res_addr_seen = mem_addr_o; end
      if (mem_wstrb_o != 4'd0) begin
        res_wstrb_cnt++; res_wstrb_off = off; res_wstrb_seen = mem_wstrb_o;
      end
      if (iomem_ready_o) begin
        res_lat = off; res_err = iomem_err_o; res_rdata = iomem_rdata_o; res_rdata_in = mem_rdata_i;
        done = 1;
      end
      @(posedge clk_i); #1;
      if (done) break;
      if (rst_at == off + 1) begin
        apply_reset();
        aborted = 1;
        break;
      end
    end
    iomem_valid_i = 1'b0;
    if (!aborted) check("txn_completed", done, 1);
  endtask

  initial begin
    int e, irq_off, c1, c2, nrdy;
    // reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ready", iomem_ready_o, 0);
    check("reset_irq", timer_irq_o, 0);
    check("reset_mem_addr", mem_addr_o, 0);
    check("reset_rdata", iomem_rdata_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset(cyc);
    chk_en = 1'b1;
    e = cyc;

    // compare = 5, irq rises the cycle after the timer reaches 5
    do_txn(32'h3000_0008, 4'hF, 32'd5, -1, -1);
    check("cmp_lo_wr_lat", res_lat, 1);
    do_txn(32'h3000_000C, 4'hF, 32'd0, -1, -1);
    check("cmp_hi_wr_lat", res_lat, 1);
    irq_off = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (timer_irq_o && irq_off < 0) irq_off = cyc - e;
      @(posedge clk_i); #1;
    end
    check("irq_rise_cycle", irq_off, 6);

    // lo = all ones; carry reaches hi only on the following increment
    apply_reset();
    do_txn(32'h3000_0000, 4'hF, 32'hFFFF_FFFF, -1, -1);
    repeat (3) begin @(posedge clk_i); #1; end
    do_txn(32'h3000_0004, 4'h0, 32'd0, -1, -1);
    check("timer_hi_after_carry", res_rdata, 1);

    // RAM read, latency 16
    do_txn(32'h4000_0010, 4'h0, 32'd0, -1, -1);
    check("ram_rd_lat", res_lat, 16);
    check("ram_rd_en_off", res_rden_off, 1);
    check("ram_rd_addr", res_addr_seen, 4);
    check("ram_rd_data", res_rdata, res_rdata_in);

    // RAM write, latency 4
    do_txn(32'h4000_0008, 4'b0011, 32'hA5A5_1234, -1, -1);
    check("ram_wr_lat", res_lat, 4);
    check("ram_wr_strb_cnt", res_wstrb_cnt, 1);
    check("ram_wr_strb_off", res_wstrb_off, 1);
    check("ram_wr_strb_val", res_wstrb_seen, 4'b0011);
    check("ram_wr_err", res_err, 0);

    // unmapped read, then back-to-back RAM read
    c1 = cyc;
    do_txn(32'h2500_0000, 4'h0, 32'd0, -1, -1);
    check("unmapped_lat", res_lat, 1);
    check("unmapped_err", res_err, 1);
    check("unmapped_rdata", res_rdata, 0);
    c2 = cyc;
    do_txn(32'h4000_0020, 4'h0, 32'd0, -1, -1);
    check("b2b_accept_cycle", c2 - c1, 2);
    check("b2b_ram_lat", res_lat, 16);

    // reset during cycle 5 of a read
    do_txn(32'h4000_0000, 4'h0, 32'd0, -1, 5);
    nrdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (iomem_ready_o) nrdy++;
      @(posedge clk_i); #1;
    end
    check("abort_no_ready", nrdy, 0);

    // randomized traffic
    for (int t = 0; t < 250; t++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      int r, lat, drop, ra;
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      r = $urandom_range(0, 9);
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      d = $urandom;
      drop = -1; ra = -1;
      if (r < 4) begin
        a = 32'h4000_0000 | ($urandom & 32'h000F_FFFC);
        lat = (s != 4'd0) ? WRL : RDL;
        if ($urandom_range(0, 3) == 0) drop = $urandom_range(1, lat - 1);
        if ($urandom_range(0, 29) == 0) ra = $urandom_range(1, lat - 1);
      end else if (r < 8) begin
        a = 32'h3000_0000 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      end else if (r == 8) begin
        a = 32'h2500_0000 | ($urandom & 32'h00FF_FFFC);
      end else begin
        a = 32'h3000_0010 + 32'($urandom_range(0, 1000)) * 32'd4;
      end
      do_txn(a, s, d, drop, ra);
    end

    repeat (4) begin @(posedge clk_i); #1; end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/iomem_latency_bridge.md
IOMEM_LATENCY_BRIDGE -- requirements
Module: iomem_latency_bridge

Interface
REQ-001 SHALL have parameter RAM_BASE_ADDR, default 32'h4000_0000, RAM region base.
REQ-002 SHALL have parameter RAM_MASK_ADDR, default 32'h000f_ffff; an address is in the RAM region when (addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR.
REQ-003 SHALL have parameter TIMER_BASE_ADDR, default 32'h3000_0000; the timer region covers offsets 0x0-0xC, word aligned.
REQ-004 SHALL have parameter RD_LATENCY, default 16, RAM read latency in cycles; legal range 2..255.
REQ-005 SHALL have parameter WR_LATENCY, default 16, RAM write latency in cycles; legal range 2..255.
REQ-006 SHALL have parameter RAM_ADDR_W, default 17, RAM word-address width.
REQ-007 SHALL use one clock and a synchronous, active-high reset, with the ports listed below.
REQ-008 clk_i  in  1  clock; all logic on rising edge.
REQ-009 rst_i  in  1  synchronous active-high reset.
REQ-010 iomem_valid_i  in  1  request valid; held until ready.
REQ-011 iomem_ready_o  out  1  single-cycle completion pulse.
REQ-012 iomem_wstrb_i  in  4  byte write strobes; 0 means read.
REQ-013 iomem_addr_i  in  32  byte address.
REQ-014 iomem_wdata_i  in  32  write data.
REQ-015 iomem_rdata_o  out  32  read data, valid only while iomem_ready_o is 1.
REQ-016 iomem_err_o  out  1  unmapped-access flag, pulses with ready.
REQ-017 mem_addr_o  out  RAM_ADDR_W  RAM word address, iomem_addr_i[RAM_ADDR_W+1:2], registered.
REQ-018 mem_wdata_o  out  32  RAM write data, registered.
REQ-019 mem_wstrb_o  out  4  RAM write strobes, single-cycle pulse.
REQ-020 mem_rd_en_o  out  1  RAM read enable, single-cycle pulse.
REQ-021 mem_rdata_i  in  32  RAM read data.
REQ-022 timer_irq_o  out  1  timer compare interrupt.

Function
REQ-023 SHALL implement the FSM states IDLE, RAM_WAIT and RESP.
REQ-024 SHALL accept a request only when the FSM is in IDLE and iomem_valid_i is 1; this cycle is cycle 0.
REQ-025 For a RAM-region accept, SHALL in cycle 1 drive mem_rd_en_o=1 (read) or mem_wstrb_o=iomem_wstrb_i (write) for exactly one cycle, and load the latency counter with RD_LATENCY-1 or WR_LATENCY-1.
REQ-026 In RAM_WAIT, SHALL decrement the counter each cycle and assert iomem_ready_o in exactly cycle RD_LATENCY (read) or WR_LATENCY (write).
REQ-027 SHALL drive iomem_rdata_o = mem_rdata_i during the RAM ready cycle, and 0 during the RAM ready cycle of a write.
REQ-028 For a timer-region or unmapped accept, SHALL go to RESP and assert iomem_ready_o in cycle 1.
REQ-029 For an unmapped access, SHALL assert iomem_err_o with ready, return rdata 32'h0, and have no side effects.
REQ-030 After each ready cycle, SHALL return to IDLE so the next accept can occur no earlier than one cycle after ready; iomem_ready_o never stays high for two consecutive cycles.
REQ-031 If iomem_valid_i drops mid-transaction (illegal), SHALL still complete the transaction on schedule, including the ready pulse.
REQ-032 The 64-bit timer SHALL increment by 1 every cycle and wrap from 2^64-1 to 0.
REQ-033 The 64-bit compare register SHALL be readable and writable.
REQ-034 Timer register map: offset 0x0 = timer[31:0], 0x4 = timer[63:32], 0x8 = cmp[31:0], 0xC = cmp[63:32].
REQ-035 Timer-region writes SHALL be byte-merged per wstrb and take effect at the cycle-1 edge; offsets 0x10 and above within the base page are unmapped.
REQ-036 A write to either timer half SHALL suppress that cycle's increment; the other half keeps its old value, with no carry.
REQ-037 Timer reads SHALL return the value registered at cycle 0.
REQ-038 timer_irq_o SHALL be registered and equal (timer >= cmp), updating one cycle after either value changes.

Reset
REQ-039 On rst_i=1, SHALL set FSM=IDLE, counter=0, iomem_ready_o=0, iomem_err_o=0, iomem_rdata_o=0, mem_rd_en_o=0, mem_wstrb_o=0, mem_addr_o=0, mem_wdata_o=0, timer=0, cmp=64'hFFFF_FFFF_FFFF_FFFF, timer_irq_o=0.
REQ-040 Reset asserted mid-transaction SHALL abort it, with no ready pulse and no pending RAM strobe afterwards.

Verification
REQ-041 Read 0x4000_0010 with RD_LATENCY=16 -> mem_rd_en_o pulses at cycle 1 with mem_addr_o=4; ready at cycle 16; rdata=mem_rdata_i.
REQ-042 Write 0x4000_0008, wstrb 4'b0011, WR_LATENCY=4 -> mem_wstrb_o=4'b0011 only in cycle 1; ready at cycle 4; err=0.
REQ-043 Write 0x3000_0008=5 and 0x3000_000C=0 -> timer_irq_o rises once the timer reaches 5; ready at cycle 1 for each write.
REQ-044 Write timer lo=32'hFFFF_FFFF, then read 0x3000_0004 after a few cycles -> hi has incremented by 1 (carry propagates on later increments only).
REQ-045 Read 0x2500_0000 -> ready and err at cycle 1, rdata=0; back-to-back RAM read accepted at cycle 2.
REQ-046 Assert rst_i at cycle 5 of a 16-cycle read -> no ready pulse; all outputs at reset values the cycle after.
